// File: rtl/xif_offload_ctrl.sv
// X-IF offload controller: issues one decoded instruction to a coprocessor, commits it and writes its result back.
// Define XIF_OFFLOAD_TIMEOUT_EN to add a result-wait watchdog limited by TIMEOUT_CYCLES.
module xif_offload_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        off_valid_i,
    output logic        off_ready_o,
    input  logic [31:0] off_instr_i,
    input  logic [31:0] off_rs0_i,
    input  logic [31:0] off_rs1_i,
    input  logic [3:0]  off_id_i,
    input  logic        kill_i,
    output logic        issue_valid_o,
    input  logic        issue_ready_i,
    output logic [31:0] issue_instr_o,
    output logic [31:0] issue_rs0_o,
    output logic [31:0] issue_rs1_o,
    output logic [3:0]  issue_id_o,
    input  logic        issue_accept_i,
    input  logic        issue_writeback_i,
    output logic        commit_valid_o,
    output logic        commit_kill_o,
    output logic [3:0]  commit_id_o,
    input  logic        result_valid_i,
    output logic        result_ready_o,
    input  logic [3:0]  result_id_i,
    input  logic [4:0]  result_rd_i,
    input  logic [31:0] result_data_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        illegal_o,
    output logic        busy_o,
    output logic        timeout_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("xif_offload_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        COMMIT,
        WAIT_RESULT,
        WB
    } state_e;

    state_e      state_q;
    logic        ready_q;
    logic        kill_q;
    logic        wb_q;
    logic        illegal_q;
    logic [31:0] instr_q;
    logic [31:0] rs0_q;
    logic [31:0] rs1_q;
    logic [3:0]  id_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic        result_match;

`ifdef XIF_OFFLOAD_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt_q;
    logic       timeout_q;
`endif

    assign result_match = result_valid_i && (result_id_i == id_q);

    // ready_q resets low so off_ready_o stays 0 under reset and rises on the first edge after release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            kill_q    <= 1'b0;
            wb_q      <= 1'b0;
            illegal_q <= 1'b0;
            instr_q   <= '0;
            rs0_q     <= '0;
            rs1_q     <= '0;
            id_q      <= '0;
            rd_q      <= '0;
            data_q    <= '0;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            illegal_q <= 1'b0;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    kill_q  <= 1'b0;
                    if (ready_q && off_valid_i) begin
                        instr_q <= off_instr_i;
                        rs0_q   <= off_rs0_i;
                        rs1_q   <= off_rs1_i;
                        id_q    <= off_id_i;
                        ready_q <= 1'b0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (kill_i) begin
                        kill_q <= 1'b1;
                    end
                    if (issue_ready_i) begin
                        if (issue_accept_i) begin
                            wb_q    <= issue_writeback_i;
                            state_q <= COMMIT;
                        end else begin
                            illegal_q <= 1'b1;
                            kill_q    <= 1'b0;
                            ready_q   <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    // A kill seen in the commit cycle itself aborts just like an earlier sticky one
                    if (kill_q || kill_i || !wb_q) begin
                        kill_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
`ifdef XIF_OFFLOAD_TIMEOUT_EN
                        wd_cnt_q <= '0;
`endif
                        state_q <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    if (result_match) begin
                        rd_q    <= result_rd_i;
                        data_q  <= result_data_i;
                        state_q <= WB;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
                    end else if (wd_cnt_q == WD_LAST) begin
                        timeout_q <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 8'd1;
`endif
                    end
                end
                WB: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign off_ready_o    = ready_q;
    assign issue_valid_o  = (state_q == ISSUE);
    assign issue_instr_o  = instr_q;
    assign issue_rs0_o    = rs0_q;
    assign issue_rs1_o    = rs1_q;
    assign issue_id_o     = id_q;
    assign commit_valid_o = (state_q == COMMIT);
    assign commit_kill_o  = (state_q == COMMIT) && (kill_q || kill_i);
    assign commit_id_o    = id_q;
    assign result_ready_o = (state_q == WAIT_RESULT);
    assign rf_we_o        = (state_q == WB) && (rd_q != 5'd0);
    assign rf_waddr_o     = rd_q;
    assign rf_wdata_o     = data_q;
    assign illegal_o      = illegal_q;
    assign busy_o         = (state_q != IDLE);
`ifdef XIF_OFFLOAD_TIMEOUT_EN
    assign timeout_o      = timeout_q;
`else
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Self-checking bench for xif_offload_ctrl: directed transactions with a register-file write scoreboard.
module tb_xif_offload_ctrl;

    localparam int TO = 10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        off_valid_i, off_ready_o;
    logic [31:0] off_instr_i, off_rs0_i, off_rs1_i;
    logic [3:0]  off_id_i;
    logic        kill_i;
    logic        issue_valid_o, issue_ready_i;
    logic [31:0] issue_instr_o, issue_rs0_o, issue_rs1_o;
    logic [3:0]  issue_id_o;
    logic        issue_accept_i, issue_writeback_i;
    logic        commit_valid_o, commit_kill_o;
    logic [3:0]  commit_id_o;
    logic        result_valid_i, result_ready_o;
    logic [3:0]  result_id_i;
    logic [4:0]  result_rd_i;
    logic [31:0] result_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        illegal_o, busy_o, timeout_o;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t sb_e;
    int  total = 0;
    int  bad = 0;
    int  illegal_cnt = 0;
    int  timeout_cnt = 0;
    int  write_cnt = 0;
    int  k;

    always #5 clk_i = ~clk_i;

    xif_offload_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .off_valid_i(off_valid_i), .off_ready_o(off_ready_o),
        .off_instr_i(off_instr_i), .off_rs0_i(off_rs0_i), .off_rs1_i(off_rs1_i),
        .off_id_i(off_id_i), .kill_i(kill_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o),
        .issue_id_o(issue_id_o), .issue_accept_i(issue_accept_i),
        .issue_writeback_i(issue_writeback_i),
        .commit_valid_o(commit_valid_o), .commit_kill_o(commit_kill_o), .commit_id_o(commit_id_o),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
        .result_id_i(result_id_i), .result_rd_i(result_rd_i), .result_data_i(result_data_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .illegal_o(illegal_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] allOuts();
        return {10'd0, off_ready_o, issue_valid_o, issue_instr_o, issue_rs0_o, issue_rs1_o,
                issue_id_o, commit_valid_o, commit_kill_o, commit_id_o, result_ready_o,
                rf_we_o, rf_waddr_o, rf_wdata_o, illegal_o, busy_o, timeout_o};
    endfunction

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Offload handshake; returns one step after the accepting edge (first ISSUE cycle)
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs0,
                                 input logic [31:0] rs1, input logic [3:0] id);
        int n = 0;
        while (!off_ready_o && n < 20) begin
            nextCycle();
            n++;
        end
        if (!off_ready_o) checkOutput("off_ready_wait", off_ready_o, 1);
        off_valid_i = 1'b1;
        off_instr_i = instr;
        off_rs0_i   = rs0;
        off_rs1_i   = rs1;
        off_id_i    = id;
        nextCycle();
        off_valid_i = 1'b0;
    endtask

    // Scoreboard: every register-file write must match the oldest expected one
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (illegal_o) illegal_cnt++;
            if (timeout_o) timeout_cnt++;
            if (rf_we_o) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("rf_unexpected_write", {rf_waddr_o, rf_wdata_o}, 0);
                end else begin
                    sb_e = exp_q.pop_front();
                    checkOutput("rf_waddr", rf_waddr_o, sb_e.addr);
                    checkOutput("rf_wdata", rf_wdata_o, sb_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        off_valid_i = 0; off_instr_i = 0; off_rs0_i = 0; off_rs1_i = 0; off_id_i = 0;
        kill_i = 0; issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0;
        result_valid_i = 0; result_id_i = 0; result_rd_i = 0; result_data_i = 0;

        repeat (2) nextCycle();
        checkOutput("reset_outputs", allOuts(), 0);
        rst_ni = 1'b1;
        nextCycle();
        checkOutput("post_reset_ready", off_ready_o, 1);
        checkOutput("post_reset_busy", busy_o, 0);

        // Accepted writeback at minimum latency
        issue_ready_i = 1; issue_accept_i = 1; issue_writeback_i = 1;
        applyStimulus(32'h0020_80AB, 32'h0000_1111, 32'h0000_2222, 4'd3);
        checkOutput("t1_issue_valid", issue_valid_o, 1);
        checkOutput("t1_issue_fields", {issue_instr_o, issue_rs0_o, issue_rs1_o, issue_id_o},
                    {32'h0020_80AB, 32'h0000_1111, 32'h0000_2222, 4'd3});
        checkOutput("t1_busy_ready", {busy_o, off_ready_o}, 2'b10);
        nextCycle();
        checkOutput("t1_commit", {issue_valid_o, commit_valid_o, commit_kill_o, commit_id_o}, {3'b010, 4'd3});
        result_valid_i = 1; result_id_i = 3; result_rd_i = 5; result_data_i = 32'hDEAD_BEEF;
        exp_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
        nextCycle();
        checkOutput("t1_wait", {commit_valid_o, result_ready_o, rf_we_o}, 3'b010);
        nextCycle();
        result_valid_i = 0;
        checkOutput("t1_rf_we", rf_we_o, 1);
        checkOutput("t1_rf_port", {rf_waddr_o, rf_wdata_o}, {5'd5, 32'hDEAD_BEEF});
        nextCycle();
        checkOutput("t1_idle", {busy_o, off_ready_o, rf_we_o}, 3'b010);

        // Rejected instruction
        issue_accept_i = 0;
        applyStimulus(32'hFFFF_0001, 32'h3, 32'h4, 4'd9);
        checkOutput("t2_issue_valid", issue_valid_o, 1);
        nextCycle();
        checkOutput("t2_illegal", {illegal_o, busy_o, commit_valid_o, off_ready_o}, 4'b1001);
        nextCycle();
        checkOutput("t2_illegal_once", {illegal_o, commit_valid_o}, 2'b00);

        // Backpressure with a kill pulse during it
        issue_ready_i = 0; issue_accept_i = 1; issue_writeback_i = 1;
        applyStimulus(32'h1234_5677, 32'hAAAA_0000, 32'h0000_BBBB, 4'd5);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_issue_held", {issue_valid_o, issue_instr_o, issue_rs0_o, issue_rs1_o, issue_id_o},
                        {1'b1, 32'h1234_5677, 32'hAAAA_0000, 32'h0000_BBBB, 4'd5});
            kill_i = (i == 1);
            nextCycle();
        end
        kill_i = 0;
        checkOutput("t3_issue_still_valid", issue_valid_o, 1);
        issue_ready_i = 1;
        nextCycle();
        checkOutput("t3_commit_kill", {commit_valid_o, commit_kill_o, commit_id_o}, {2'b11, 4'd5});
        nextCycle();
        checkOutput("t3_idle", {busy_o, rf_we_o, result_ready_o}, 3'b000);

        // Id filter: mismatching result dropped, matching one written
        applyStimulus(32'h0000_0033, 32'h5, 32'h6, 4'd3);
        nextCycle();
        checkOutput("t4_commit_no_kill", {commit_valid_o, commit_kill_o}, 2'b10);
        result_valid_i = 1; result_id_i = 7; result_rd_i = 9; result_data_i = 32'h1111_1111;
        nextCycle();
        checkOutput("t4_ready_for_drop", result_ready_o, 1);
        nextCycle();
        checkOutput("t4_after_drop", {busy_o, result_ready_o, rf_we_o}, 3'b110);
        result_id_i = 3; result_rd_i = 12; result_data_i = 32'hCAFE_F00D;
        exp_q.push_back('{addr: 5'd12, data: 32'hCAFE_F00D});
        nextCycle();
        result_valid_i = 0;
        checkOutput("t4_rf_write", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 5'd12, 32'hCAFE_F00D});
        nextCycle();

        // Result to x0 is not written
        applyStimulus(32'h0000_0044, 32'h7, 32'h8, 4'd3);
        nextCycle();
        result_valid_i = 1; result_id_i = 3; result_rd_i = 0; result_data_i = 32'h5555_5555;
        nextCycle();
        nextCycle();
        result_valid_i = 0;
        checkOutput("t4_rd0_no_write", {busy_o, rf_we_o}, 2'b10);
        nextCycle();
        checkOutput("t4_rd0_idle", busy_o, 0);

        // Watchdog
        applyStimulus(32'h0000_0055, 32'h9, 32'hA, 4'd4);
        nextCycle();
        nextCycle();
        checkOutput("t5_wait_entry", result_ready_o, 1);
`ifdef XIF_OFFLOAD_TIMEOUT_EN
        k = 0;
        while (k < 40 && !timeout_o) begin
            nextCycle();
            k++;
        end
        checkOutput("t5_timeout_delay", k, TO);
        checkOutput("t5_idle_at_timeout", {busy_o, rf_we_o}, 2'b00);
        nextCycle();
        checkOutput("t5_timeout_once", timeout_o, 0);
        applyStimulus(32'h0000_0066, 32'hB, 32'hC, 4'd6);
        nextCycle();
        nextCycle();
`else
        repeat (30) nextCycle();
        checkOutput("t5_waits_forever", {busy_o, result_ready_o, timeout_o}, 3'b110);
`endif

        // Reset in the middle of WAIT_RESULT
        nextCycle();
        checkOutput("t6_in_wait", result_ready_o, 1);
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_reset_async", allOuts(), 0);
        repeat (3) nextCycle();
        checkOutput("t6_reset_held", allOuts(), 0);
        rst_ni = 1'b1;
        nextCycle();
        checkOutput("t6_ready_after_release", {off_ready_o, busy_o}, 2'b10);
        applyStimulus(32'h0000_0077, 32'hD, 32'hE, 4'd2);
        nextCycle();
        result_valid_i = 1; result_id_i = 2; result_rd_i = 31; result_data_i = 32'hA5A5_A5A5;
        exp_q.push_back('{addr: 5'd31, data: 32'hA5A5_A5A5});
        nextCycle();
        nextCycle();
        result_valid_i = 0;
        checkOutput("t6_rf_write", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 5'd31, 32'hA5A5_A5A5});
        nextCycle();
        checkOutput("t6_idle", busy_o, 0);

        checkOutput("illegal_pulse_count", illegal_cnt, 1);
`ifdef XIF_OFFLOAD_TIMEOUT_EN
        checkOutput("timeout_pulse_count", timeout_cnt, 1);
`else
        checkOutput("timeout_pulse_count", timeout_cnt, 0);
`endif
        checkOutput("rf_write_count", write_cnt, 3);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
